// File: rtl/vp415_video_pkg.sv
// vp415_video_pkg: shared video timing defaults and counter sizing helper
package vp415_video_pkg;
  localparam int VP_LINE_NOM = 6400;
  localparam int VP_PIX_PER_LINE = 864;
  function automatic int cnt_w(input int line_nom, input int line_tol);
    return $clog2(line_nom + line_tol + 1);
  endfunction
endpackage

// File: rtl/pixel_nco.sv
// pixel_nco: spreads PIX_PER_LINE pixel enables evenly over one line period
module pixel_nco
  import vp415_video_pkg::*;
#(
  parameter int PIX_PER_LINE = VP_PIX_PER_LINE,
  parameter int CNT_W = 13,
  localparam int PIX_W = $clog2(PIX_PER_LINE)
) (
  input  logic             clk_100mhz,
  input  logic             reset,
  input  logic             restart,
  input  logic [CNT_W-1:0] period,
  output logic             pix_ce,
  output logic [PIX_W-1:0] pix_x
);
  localparam logic [CNT_W:0] STEP = (CNT_W+1)'(PIX_PER_LINE);
  localparam logic [PIX_W:0] LAST = (PIX_W+1)'(PIX_PER_LINE);
  logic [CNT_W:0] acc_q, acc_d, acc_sum;
  logic [PIX_W:0] idx_q, idx_d;
  logic [PIX_W-1:0] pix_x_q;
  logic pix_ce_q, active, fire;
  always_comb begin
    acc_sum = acc_q + STEP;
    active = idx_q < LAST;
    fire = active && acc_sum >= {1'b0, period};
    idx_d = restart ? (PIX_W+1)'(1) : fire ? idx_q + (PIX_W+1)'(1) : idx_q;
    // accumulator is frozen once the line's pixels are done so it can never grow unbounded
    acc_d = restart ? '0 : fire ? acc_sum - {1'b0, period} : active ? acc_sum : acc_q;
  end
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      acc_q <= '0;
      idx_q <= LAST;
      pix_ce_q <= 1'b0;
      pix_x_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      pix_ce_q <= restart | fire;
      pix_x_q <= restart ? '0 : fire ? idx_q[PIX_W-1:0] : pix_x_q;
    end
  end
  assign pix_ce = pix_ce_q;
  assign pix_x = pix_x_q;
endmodule

// File: rtl/csync_line_lock_nco.sv
// csync_line_lock_nco: qualifies csync line edges, flywheels missing lines, tracks lock, drives pixel NCO
module csync_line_lock_nco
  import vp415_video_pkg::*;
#(
  parameter int LINE_NOM = VP_LINE_NOM,
  parameter int LINE_TOL = 64,
  parameter int PIX_PER_LINE = VP_PIX_PER_LINE,
  parameter int LOCK_LINES = 8,
  parameter int MISS_MAX = 4,
  parameter int JIT_TOL = 4,
  parameter int CSYNC_ACTIVE_LOW = 1,
  localparam int CNT_W = cnt_w(LINE_NOM, LINE_TOL),
  localparam int PIX_W = $clog2(PIX_PER_LINE)
) (
  input  logic             clk_100mhz,
  input  logic             reset,
  input  logic             csync,
  output logic             pix_ce,
  output logic [PIX_W-1:0] pix_x,
  output logic             line_start,
  output logic [CNT_W-1:0] line_period,
  output logic             missed,
  output logic             locked
);
  localparam logic IDLE = CSYNC_ACTIVE_LOW != 0;
  localparam int ST_W = $clog2(LOCK_LINES + 1);
  localparam int MS_W = $clog2(MISS_MAX + 1);
  localparam logic [CNT_W:0] WIN_LO = (CNT_W+1)'(LINE_NOM - LINE_TOL);
  localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(LINE_NOM + LINE_TOL);
  localparam logic [CNT_W:0] JIT = (CNT_W+1)'(JIT_TOL);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(LOCK_LINES);
  localparam logic [MS_W-1:0] MS_MAX = MS_W'(MISS_MAX);
  logic [2:0] sync_q;
  logic acq_q, line_start_q, missed_q;
  logic [CNT_W-1:0] lc_q, lc_d, period_q, period_d;
  logic [ST_W-1:0] stable_q, stable_d;
  logic [MS_W-1:0] miss_q, miss_d;
  logic [CNT_W:0] lc_inc, diff;
  logic sync_edge, accept, timeout, fly, measure;
  always_comb begin
    sync_edge = (sync_q[1] ^ IDLE) & ~(sync_q[2] ^ IDLE);
    lc_inc = {1'b0, lc_q} + (CNT_W+1)'(1);
    diff = lc_inc > {1'b0, period_q} ? lc_inc - {1'b0, period_q} : {1'b0, period_q} - lc_inc;
    accept = sync_edge && (acq_q || (lc_inc >= WIN_LO && lc_inc <= WIN_HI));
    timeout = lc_inc > WIN_HI;
    fly = timeout && !accept && !acq_q;
    measure = accept && !acq_q;
    // while acquiring there is no line to flywheel, so lc just parks at the window end
    lc_d = accept ? '0 : !timeout ? lc_inc[CNT_W-1:0] : acq_q ? lc_q : CNT_W'(LINE_TOL);
    period_d = measure ? lc_inc[CNT_W-1:0] : period_q;
    miss_d = accept ? '0 : (fly && miss_q != MS_MAX) ? miss_q + MS_W'(1) : miss_q;
    stable_d = measure ? (diff > JIT ? '0 : stable_q == ST_MAX ? stable_q : stable_q + ST_W'(1))
             : (fly && miss_d == MS_MAX) ? '0 : stable_q;
  end
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      sync_q <= {3{IDLE}};
      acq_q <= 1'b1;
      lc_q <= '0;
      period_q <= CNT_W'(LINE_NOM);
      stable_q <= '0;
      miss_q <= '0;
      line_start_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], csync};
      acq_q <= acq_q & ~sync_edge;
      lc_q <= lc_d;
      period_q <= period_d;
      stable_q <= stable_d;
      miss_q <= miss_d;
      line_start_q <= accept;
      missed_q <= fly;
    end
  end
  assign line_start = line_start_q;
  assign missed = missed_q;
  assign line_period = period_q;
  assign locked = stable_q == ST_MAX;
  pixel_nco #(.PIX_PER_LINE(PIX_PER_LINE), .CNT_W(CNT_W)) u_nco (
    .clk_100mhz(clk_100mhz),
    .reset(reset),
    .restart(accept | fly),
    .period(period_q),
    .pix_ce(pix_ce),
    .pix_x(pix_x)
  );
endmodule

// File: tb/tb_csync_line_lock_nco.sv
// tb_csync_line_lock_nco: directed csync scenarios against a timeline model of line lock and pixel spacing
module tb_csync_line_lock_nco;
  localparam int NOM = 640, TOL = 16, PIX = 86, LOCKN = 8, MISSN = 4, JIT = 4;
  localparam int CW = $clog2(NOM + TOL + 1), PW = $clog2(PIX);
  logic clk = 0, rst = 1, cs = 1;
  logic pix_ce, line_start, missed, locked;
  logic [PW-1:0] pix_x;
  logic [CW-1:0] line_period;
  csync_line_lock_nco #(
    .LINE_NOM(NOM), .LINE_TOL(TOL), .PIX_PER_LINE(PIX), .LOCK_LINES(LOCKN),
    .MISS_MAX(MISSN), .JIT_TOL(JIT), .CSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk_100mhz(clk), .reset(rst), .csync(cs), .pix_ce(pix_ce), .pix_x(pix_x),
    .line_start(line_start), .line_period(line_period), .missed(missed), .locked(locked)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  int edge_q[$];
  int m_bnd, m_pst = -1, m_per = NOM, m_stab = 0, m_miss = 0, m_ls, m_ms, m_pce, m_px;
  int m_d, m_n, m_k, m_kp;
  bit m_acq = 1, m_valid = 0, m_e, m_rs;
  int n_pix = 0, n_ls = 0, n_ms = 0, max_px = 0, p0, l0, s0;
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", nm, got, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse(input int len, input int w);
    cs = 0;
    edge_q.push_back(cyc + 3);
    step(w);
    cs = 1;
    step(len - w);
  endtask
  // timeline model: boundaries, window, flywheel, lock, and pixel k at ceil(k*T/PIX) after restart
  initial forever begin
    @(posedge clk);
    cyc++;
    while (edge_q.size() > 0 && edge_q[0] < cyc) void'(edge_q.pop_front());
    m_e = edge_q.size() > 0 && edge_q[0] == cyc;
    m_ls = 0;
    m_ms = 0;
    m_rs = 0;
    if (rst) begin
      m_valid = 1; m_acq = 1; m_bnd = cyc; m_per = NOM; m_stab = 0; m_miss = 0;
      m_pst = -1; m_pce = 0; m_px = 0;
    end else begin
      m_d = cyc - m_bnd;
      if (m_e && (m_acq || (m_d >= NOM - TOL && m_d <= NOM + TOL))) begin
        if (!m_acq) begin
          m_stab = ((m_d > m_per ? m_d - m_per : m_per - m_d) <= JIT) ? (m_stab < LOCKN ? m_stab + 1 : LOCKN) : 0;
          m_per = m_d;
        end
        m_acq = 0; m_miss = 0; m_ls = 1; m_bnd = cyc; m_rs = 1;
      end else if (!m_acq && m_d == NOM + TOL + 1) begin
        m_ms = 1; m_bnd = cyc - TOL; m_miss++; m_rs = 1;
        if (m_miss >= MISSN) m_stab = 0;
      end
      if (m_rs) begin
        m_pst = cyc; m_pce = 1; m_px = 0;
      end else if (m_pst >= 0) begin
        m_n = cyc - m_pst;
        m_k = m_n * PIX / m_per;
        m_kp = (m_n - 1) * PIX / m_per;
        m_pce = (m_k != m_kp && m_k < PIX) ? 1 : 0;
        if (m_pce != 0) m_px = m_k;
      end else m_pce = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("line_start", int'(line_start), m_ls);
      chk("missed", int'(missed), m_ms);
      chk("pix_ce", int'(pix_ce), m_pce);
      if (m_pce != 0) chk("pix_x", int'(pix_x), m_px);
      chk("line_period", int'(line_period), m_per);
      chk("locked", int'(locked), m_stab >= LOCKN ? 1 : 0);
      n_pix += int'(pix_ce);
      n_ls += int'(line_start);
      n_ms += int'(missed);
      if (pix_ce && int'(pix_x) > max_px) max_px = int'(pix_x);
    end
  end
  initial begin
    step(4);
    chk("rst_pix_ce", int'(pix_ce), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_line_start", int'(line_start), 0);
    chk("rst_missed", int'(missed), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_period", int'(line_period), 640);
    rst = 0;
    step(20);
    chk("idle_no_pix", n_pix, 0);
    for (int i = 0; i < 8; i++) pulse(NOM, 47);
    chk("not_yet_locked", int'(locked), 0);
    p0 = n_pix;
    pulse(NOM, 47);
    chk("pix_per_line", n_pix - p0, 86);
    chk("lock_after_8", int'(locked), 1);
    chk("max_pix_x", max_px, 85);
    s0 = n_ms;
    l0 = n_ls;
    repeat (6) pulse(NOM / 2, 23);
    repeat (6) pulse(NOM / 2, NOM / 2 - 48);
    repeat (6) pulse(NOM / 2, 23);
    pulse(NOM, 47);
    chk("field_no_miss", n_ms - s0, 0);
    chk("field_lines", n_ls - l0, 10);
    chk("field_locked", int'(locked), 1);
    pulse(638, 47);
    pulse(642, 47);
    chk("jit_period_a", int'(line_period), 638);
    p0 = n_pix;
    pulse(NOM, 47);
    chk("jit_period_b", int'(line_period), 642);
    chk("jit_pix", n_pix - p0, 86);
    chk("jit_locked", int'(locked), 1);
    s0 = n_ms;
    pulse(6 * NOM, 47);
    chk("loss_misses", n_ms - s0, 5);
    chk("loss_unlocked", int'(locked), 0);
    pulse(NOM, 47);
    chk("recover_period", int'(line_period), 635);
    repeat (9) pulse(NOM, 47);
    chk("relocked", int'(locked), 1);
    repeat (2) pulse(630, 47);
    chk("step_unlock", int'(locked), 0);
    chk("step_period", int'(line_period), 630);
    p0 = n_pix;
    repeat (8) pulse(630, 47);
    chk("step_pix", n_pix - p0, 8 * 86);
    chk("step_relock", int'(locked), 1);
    cs = 0;
    edge_q.push_back(cyc + 3);
    step(47);
    cs = 1;
    step(300);
    rst = 1;
    step(1);
    chk("mid_rst_pix_ce", int'(pix_ce), 0);
    chk("mid_rst_pix_x", int'(pix_x), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_period", int'(line_period), 640);
    chk("mid_rst_ls", int'(line_start), 0);
    rst = 0;
    step(100);
    l0 = n_ls;
    p0 = n_pix;
    pulse(NOM, 47);
    chk("reacq_start", n_ls - l0, 1);
    chk("reacq_period", int'(line_period), 640);
    chk("reacq_pix", n_pix - p0, 86);
    step(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
